// File: rtl/video_pkg.sv
// Shared constants and types for the video I/O front-end.
package video_pkg;

  localparam logic [1:0] PORT_CTRL = 2'd0;
  localparam logic [1:0] PORT_PC   = 2'd1;
  localparam logic [1:0] PORT_PB   = 2'd2;
  localparam logic [1:0] PORT_PA   = 2'd3;

  localparam logic [7:0] PAL_BASE_DEFAULT = 8'h0C;

  localparam int MODE512_BIT = 4;
  localparam int BORDER_MSB  = 3;

  typedef enum logic [0:0] {
    INT_IDLE = 1'b0,
    INT_PEND = 1'b1
  } int_state_t;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: rise is high in the cycle the input first reads 1.
// The delay register tracks the input through reset too, so no edge appears after reset.
module edge_rise (
  input  logic clk_sys,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge clk_sys) begin
    din_d <= din;
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/video_ctrl.sv
// CPU port decode for scroll/border/mode512/port C and palette writes, plus the frame
// interrupt request with INTA handshake and hold-timeout. Register updates land 1 cycle after the io_wr edge.
module video_ctrl
  import video_pkg::*;
#(
  parameter logic [15:0] INT_HOLD  = 16'd4096,
  parameter logic [7:0]  PORT_BASE = 8'h00,
  parameter logic [7:0]  PAL_BASE  = PAL_BASE_DEFAULT
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_din,
  input  logic       io_wr,
  input  logic       retrace,
  input  logic       inta,
  output logic [7:0] scroll,
  output logic [3:0] border,
  output logic       mode512,
  output logic [7:0] port_c,
  output logic       pal_we,
  output logic [7:0] pal_data,
  output logic       int_req
);

  logic wr_ev;
  logic ret_ev;
  logic ack_ev;

  edge_rise u_wr_edge  (.clk_sys(clk_sys), .din(io_wr),   .rise(wr_ev));
  edge_rise u_ret_edge (.clk_sys(clk_sys), .din(retrace), .rise(ret_ev));
  edge_rise u_ack_edge (.clk_sys(clk_sys), .din(inta),    .rise(ack_ev));

  logic [7:0] port_off;
  logic       port_hit;
  logic       pal_hit;

  assign port_off = io_addr - PORT_BASE;
  assign port_hit = wr_ev && (port_off[7:2] == 6'd0);
  assign pal_hit  = wr_ev && (io_addr[7:2] == PAL_BASE[7:2]);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      scroll   <= 8'hFF;
      border   <= 4'h0;
      mode512  <= 1'b0;
      port_c   <= 8'h00;
      pal_we   <= 1'b0;
      pal_data <= 8'h00;
    end else begin
      pal_we <= 1'b0;
      if (pal_hit) begin
        pal_we   <= 1'b1;
        pal_data <= io_din;
      end
      if (port_hit) begin
        case (port_off[1:0])
          PORT_CTRL: begin
            // Mode set clears every output latch; otherwise it is a single-bit set/reset on port C.
            if (io_din[7]) begin
              scroll  <= 8'h00;
              border  <= 4'h0;
              mode512 <= 1'b0;
              port_c  <= 8'h00;
            end else begin
              port_c[io_din[3:1]] <= io_din[0];
            end
          end
          PORT_PC: port_c <= io_din;
          PORT_PB: begin
            border  <= io_din[BORDER_MSB:0];
            mode512 <= io_din[MODE512_BIT];
          end
          PORT_PA: scroll <= io_din;
        endcase
      end
    end
  end

  int_state_t  int_state;
  logic [15:0] hold_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      int_state <= INT_IDLE;
      hold_cnt  <= 16'd0;
    end else if (ret_ev) begin
      // A new frame always restarts the request, even over a same-cycle acknowledge.
      int_state <= INT_PEND;
      hold_cnt  <= 16'd0;
    end else if (int_state == INT_PEND) begin
      if (ack_ev || (hold_cnt == INT_HOLD - 16'd1)) begin
        int_state <= INT_IDLE;
      end else if (hold_cnt != 16'hFFFF) begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

  assign int_req = (int_state == INT_PEND);

endmodule

// File: tb/tb_video_ctrl.sv
// Randomised + directed bench for video_ctrl; expected outputs are queued per cycle and checked by a monitor.
module tb_video_ctrl;

  localparam int HOLD = 16;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] io_addr = 8'h00;
  logic [7:0] io_din  = 8'h00;
  logic       io_wr   = 1'b0;
  logic       retrace = 1'b0;
  logic       inta    = 1'b0;
  logic [7:0] scroll;
  logic [3:0] border;
  logic       mode512;
  logic [7:0] port_c;
  logic       pal_we;
  logic [7:0] pal_data;
  logic       int_req;

  video_ctrl #(.INT_HOLD(16'(HOLD)), .PORT_BASE(8'h00), .PAL_BASE(8'h0C)) dut (
    .clk_sys(clk_sys), .reset(reset), .io_addr(io_addr), .io_din(io_din), .io_wr(io_wr),
    .retrace(retrace), .inta(inta), .scroll(scroll), .border(border), .mode512(mode512),
    .port_c(port_c), .pal_we(pal_we), .pal_data(pal_data), .int_req(int_req)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         tag;
    logic [7:0] scroll;
    logic [3:0] border;
    logic       m512;
    logic [7:0] pc;
    logic       irq;
    logic       pwe;
    logic [7:0] pdat;
  } snap_t;

  snap_t      exp_q[$];
  logic [7:0] pal_q[$];
  snap_t      cur;
  logic [7:0] pd;

  // Reference model state, in plain integers.
  int m_scroll = 255, m_border = 0, m_m512 = 0, m_pc = 0, m_pal = 0;
  bit m_irq = 0;
  int m_deadline = 0;
  bit p_wr = 0, p_ret = 0, p_ack = 0;
  bit cur_ret = 0, cur_ack = 0;

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input bit w, input bit r,
                       input bit k, input bit rst);
    int e;
    int b;
    bit pwe;
    e   = cyc + 1;
    pwe = 0;
    io_addr = a; io_din = d; io_wr = w; retrace = r; inta = k; reset = rst;
    if (rst) begin
      m_scroll = 255; m_border = 0; m_m512 = 0; m_pc = 0; m_pal = 0; m_irq = 0;
    end else begin
      if (w && !p_wr) begin
        if (a == 8'h00) begin
          if (d[7]) begin
            m_scroll = 0; m_border = 0; m_m512 = 0; m_pc = 0;
          end else begin
            b = int'(d[3:1]);
            if (d[0]) m_pc = m_pc | (1 << b);
            else      m_pc = m_pc & ~(1 << b) & 255;
          end
        end else if (a == 8'h01) m_pc = int'(d);
        else if (a == 8'h02) begin
          m_border = int'(d) & 15;
          m_m512   = (int'(d) >> 4) & 1;
        end else if (a == 8'h03) m_scroll = int'(d);
        else if (a >= 8'h0C && a <= 8'h0F) begin
          m_pal = int'(d);
          pwe   = 1;
          pal_q.push_back(d);
        end
      end
      if (r && !p_ret) begin
        m_irq = 1;
        m_deadline = e + HOLD;
      end else if (m_irq && k && !p_ack) m_irq = 0;
      else if (m_irq && e >= m_deadline) m_irq = 0;
    end
    p_wr = w; p_ret = r; p_ack = k;
    exp_q.push_back('{e, 8'(m_scroll), 4'(m_border), 1'(m_m512), 8'(m_pc), m_irq, pwe, 8'(m_pal)});
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'hEE, 8'h00, 1'b0, cur_ret, cur_ack, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    drive(a, d, 1'b1, cur_ret, cur_ack, 1'b0);
    drive(a, d, 1'b0, cur_ret, cur_ack, 1'b0);
  endtask

  task automatic set_lines(input bit r, input bit k);
    cur_ret = r; cur_ack = k;
    drive(8'hEE, 8'h00, 1'b0, cur_ret, cur_ack, 1'b0);
  endtask

  always @(negedge clk_sys) begin
    while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      cur = exp_q.pop_front();
      total++; bad++;
      $display("FAIL stale_expect tag=%0d now=%0d", cur.tag, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      cur = exp_q.pop_front();
      total++;
      if ({scroll, border, mode512, port_c, int_req, pal_we, pal_data} !==
          {cur.scroll, cur.border, cur.m512, cur.pc, cur.irq, cur.pwe, cur.pdat}) begin
        bad++;
        $display("FAIL regs cyc=%0d got scroll=%h border=%h m512=%b pc=%h irq=%b we=%b pd=%h want scroll=%h border=%h m512=%b pc=%h irq=%b we=%b pd=%h",
                 cyc, scroll, border, mode512, port_c, int_req, pal_we, pal_data,
                 cur.scroll, cur.border, cur.m512, cur.pc, cur.irq, cur.pwe, cur.pdat);
      end
    end
    if (pal_we === 1'b1) begin
      total++;
      if (pal_q.size() == 0) begin
        bad++;
        $display("FAIL pal_unexpected cyc=%0d got pal_we=1 data=%h want no pulse", cyc, pal_data);
      end else begin
        pd = pal_q.pop_front();
        if (pal_data !== pd) begin
          bad++;
          $display("FAIL pal_data cyc=%0d got %h want %h", cyc, pal_data, pd);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  logic [7:0] addrs [9];

  initial begin
    addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};

    // Reset, then quiet bus.
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Held io_wr is a single write.
    for (int i = 0; i < 5; i++) drive(8'h02, 8'h1A, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    wr(8'h03, 8'h40);
    wr(8'h00, 8'h0B);
    wr(8'h00, 8'h0A);
    wr(8'h00, 8'h80);
    idle(1);

    wr(8'h0C, 8'h3F);
    wr(8'h0F, 8'hC0);
    wr(8'h10, 8'h55);
    idle(2);

    // Retrace then INTA 10 cycles later.
    set_lines(1'b1, 1'b0);
    idle(9);
    set_lines(1'b1, 1'b1);
    set_lines(1'b0, 1'b0);
    idle(3);

    // No INTA: hold timeout.
    set_lines(1'b1, 1'b0);
    set_lines(1'b0, 1'b0);
    idle(20);

    // Coincident retrace and INTA rise while pending.
    set_lines(1'b1, 1'b0);
    set_lines(1'b0, 1'b0);
    idle(4);
    set_lines(1'b1, 1'b1);
    idle(5);
    set_lines(1'b0, 1'b0);
    idle(20);

    // Reset while pending.
    set_lines(1'b1, 1'b0);
    idle(3);
    drive(8'hEE, 8'h00, 1'b0, cur_ret, cur_ack, 1'b1);
    set_lines(1'b0, 1'b0);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      bit w;
      bit rst;
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 8)];
      d = 8'($urandom);
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) cur_ret = ~cur_ret;
      if ($urandom_range(0, 5) == 0)  cur_ack = ~cur_ack;
      rst = ($urandom_range(0, 299) == 0);
      drive(a, d, w, cur_ret, cur_ack, rst);
    end
    idle(2);

    @(negedge clk_sys);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL expect_drain got %0d left want 0", exp_q.size());
    end
    total++;
    if (pal_q.size() != 0) begin
      bad++;
      $display("FAIL pal_drain got %0d left want 0", pal_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
